uc_seq: RTL and testbench
=========================

UC_SEQ -- requirements
Module: uc_seq

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-low reset (0 at clk edge resets block).
REQ-002 SHALL have inputs: opcode  in  6  current instruction [15:10]; z  in  1  zero flag from datapath; start  in  1  run request; stop  in  1  pause request; step_req  in  1  single-step request.
REQ-003 SHALL have datapath control outputs: s_ret, s_rre, s_inc, s_inm, we3, wez  out  1 each; op  out  3  ALU op; pc_we  out  1  PC load enable (top level gates PC update with it).
REQ-004 SHALL have status outputs: running  out  1; halted  out  1; step_ack  out  1; illegal  out  1 sticky; call_err  out  1 sticky; instr_cnt  out  16  executed-instruction count.

Function
REQ-005 Decode SHALL be: opcode[5]=0 -> ALU, op=opcode[4:2], we3=1, wez=1, s_inc=1; opcode[5:2]=1000 -> li, we3=1, s_inm=1, s_inc=1.
REQ-006 SHALL decode full opcode: 100100 j (s_inc=0); 100101 jz (s_inc=~z); 100110 jnz (s_inc=z); 100111 jal (s_inc=0, s_rre=1); 101000 ret (s_ret=1); 101001 halt; all other values illegal.
REQ-007 Branch/jump/ret/halt/illegal SHALL drive we3=0, wez=0, s_inm=0; op SHALL be 000 for non-ALU instructions.
REQ-008 Illegal opcode SHALL execute as nop (s_inc=1, no writes) and set illegal.
REQ-009 Internal exec SHALL be 1 iff reset=1 and (state=RUN, or state=IDLE with step_req=1 and start=0).
REQ-010 we3, wez, s_rre, pc_we SHALL be the decoded value ANDed with exec; s_ret, s_inc, s_inm, op SHALL be pure decode.
REQ-011 halt SHALL drive pc_we=0 (PC stays on halt word).
REQ-012 FSM states SHALL be IDLE, RUN, HALT; running=1 only in RUN; halted=1 only in HALT.
REQ-013 IDLE: start=1 -> RUN next cycle, no instruction executed this cycle; start=0 and step_req=1 -> one instruction executed this cycle, stay IDLE (or HALT if it was halt).
REQ-014 RUN: stop=1 -> IDLE, no instruction executed this cycle (exec forced 0); otherwise execute one instruction per cycle.
REQ-015 Executed halt SHALL move to HALT next cycle; HALT SHALL ignore start, stop, step_req until reset.
REQ-016 step_ack SHALL pulse 1 for exactly one cycle, the cycle after a step executes; step_req held high SHALL step once per cycle.
REQ-017 Internal rr_valid SHALL set on executed jal and clear on executed ret.
REQ-018 Executed jal with rr_valid=1, or executed ret with rr_valid=0, SHALL set call_err; the instruction still executes normally.
REQ-019 instr_cnt SHALL increment by 1 per cycle with exec=1 (halt and illegal included), wrapping 0xFFFF -> 0x0000.
REQ-020 start and stop both 1 in RUN SHALL resolve as stop.

Reset
REQ-021 reset=0 at clk edge SHALL set state=IDLE, rr_valid=0, illegal=0, call_err=0, instr_cnt=0, step_ack=0, from any state including mid-run.
REQ-022 While reset=0, exec SHALL be 0, so we3, wez, s_rre, pc_we read 0.
REQ-023 Block SHALL take no action on the first cycle after reset deasserts unless start or step_req is 1.

Verification
REQ-024 reset low 2 cycles, start=1 one cycle, opcode=000100 -> running=1 next cycle; then we3=1, wez=1, op=001, pc_we=1, instr_cnt 0->1.
REQ-025 RUN, opcode=100101: z=1 -> s_inc=0; z=0 -> s_inc=1; we3=0, wez=0, pc_we=1 in both cases.
REQ-026 RUN, jal, then jal, then ret, then ret -> s_rre=1 on both jal; call_err=0 after first jal, 1 after second, stays 1 through both ret.
REQ-027 IDLE, step_req=1 one cycle, opcode=100000 (li) -> we3=1, s_inm=1 that cycle, step_ack=1 next cycle only, instr_cnt=1, state stays IDLE.
REQ-028 RUN, opcode=101001 -> pc_we=0, halted=1 next cycle; start=1 and step_req=1 then give no exec, instr_cnt frozen; reset=0 -> IDLE, flags 0, instr_cnt=0.
REQ-029 instr_cnt preloaded to 0xFFFF by running 65535 nops (opcode=111111) -> illegal=1, next exec wraps instr_cnt to 0x0000.

Source files
------------

// File: rtl/uc_seq.sv
// Microcoded sequencer for a small 16-bit core: decodes the opcode into datapath
// controls and runs the IDLE/RUN/HALT execution FSM with step, counter and error tracking.
module uc_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        z,
    input  logic        start,
    input  logic        stop,
    input  logic        step_req,
    output logic        s_ret,
    output logic        s_rre,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we3,
    output logic        wez,
    output logic [2:0]  op,
    output logic        pc_we,
    output logic        running,
    output logic        halted,
    output logic        step_ack,
    output logic        illegal,
    output logic        call_err,
    output logic [15:0] instr_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t state, state_next;
    logic   rr_valid;
    logic   exec;
    logic   d_we3, d_wez, d_rre, d_pc_we;
    logic   is_jal, is_ret, is_halt, is_illegal;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        s_ret      = 1'b0;
        d_rre      = 1'b0;
        s_inc      = 1'b1;
        s_inm      = 1'b0;
        d_we3      = 1'b0;
        d_wez      = 1'b0;
        op         = 3'b000;
        d_pc_we    = 1'b1;
        is_jal     = 1'b0;
        is_ret     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (!opcode[5]) begin
            op    = opcode[4:2];
            d_we3 = 1'b1;
            d_wez = 1'b1;
        end else if (opcode[5:2] == 4'b1000) begin
            d_we3 = 1'b1;
            s_inm = 1'b1;
        end else begin
            unique case (opcode)
                6'b100100: s_inc = 1'b0;
                6'b100101: s_inc = ~z;
                6'b100110: s_inc = z;
                6'b100111: begin
                    s_inc  = 1'b0;
                    d_rre  = 1'b1;
                    is_jal = 1'b1;
                end
                6'b101000: begin
                    s_inc  = 1'b0;
                    s_ret  = 1'b1;
                    is_ret = 1'b1;
                end
                6'b101001: begin
                    s_inc   = 1'b0;
                    d_pc_we = 1'b0;
                    is_halt = 1'b1;
                end
                default: is_illegal = 1'b1;
            endcase
        end
    end

    // A stop in RUN and a start in IDLE both suppress execution for that cycle.
    assign exec = reset && ((state == RUN && !stop) ||
                            (state == IDLE && step_req && !start));

    assign we3   = d_we3   & exec;
    assign wez   = d_wez   & exec;
    assign s_rre = d_rre   & exec;
    assign pc_we = d_pc_we & exec;

    assign running = (state == RUN);
    assign halted  = (state == HALT);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start)                state_next = RUN;
                else if (exec && is_halt) state_next = HALT;
            end
            RUN: begin
                if (stop)                 state_next = IDLE;
                else if (is_halt)         state_next = HALT;
            end
            HALT:                         state_next = HALT;
            default:                      state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rr_valid  <= 1'b0;
            illegal   <= 1'b0;
            call_err  <= 1'b0;
            instr_cnt <= 16'h0000;
            step_ack  <= 1'b0;
        end else begin
            state    <= state_next;
            step_ack <= exec && (state == IDLE);
            if (exec) begin
                instr_cnt <= instr_cnt + 16'd1;
                if (is_illegal)                        illegal  <= 1'b1;
                if ((is_jal && rr_valid) || (is_ret && !rr_valid)) call_err <= 1'b1;
                if (is_jal)      rr_valid <= 1'b1;
                else if (is_ret) rr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uc_seq.sv
// Directed self-checking bench for uc_seq: inputs change 1ns after a rising edge,
// outputs are compared between edges against hand-computed values.
module tb_uc_seq;

    logic        clk = 1'b0;
    logic        reset, z, start, stop, step_req;
    logic [5:0]  opcode;
    logic        s_ret, s_rre, s_inc, s_inm, we3, wez, pc_we;
    logic [2:0]  op;
    logic        running, halted, step_ack, illegal, call_err;
    logic [15:0] instr_cnt;

    int checks   = 0;
    int failures = 0;

    uc_seq dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .start(start),
        .stop(stop), .step_req(step_req), .s_ret(s_ret), .s_rre(s_rre),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .op(op),
        .pc_we(pc_we), .running(running), .halted(halted), .step_ack(step_ack),
        .illegal(illegal), .call_err(call_err), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then leave 1ns so registered outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; z = 1'b0; start = 1'b0; stop = 1'b0; step_req = 1'b0;
        opcode = 6'b000100;
        #1;
        check("rst_we3", we3, 0);
        check("rst_pc_we", pc_we, 0);
        check("rst_op_decode", op, 3'b001);
        tick(); tick();
        check("rst_running", running, 0);
        check("rst_halted", halted, 0);
        check("rst_cnt", instr_cnt, 16'h0000);
        check("rst_step_ack", step_ack, 0);
        check("rst_flags", {illegal, call_err}, 0);

        // Start: no instruction during the start cycle
        reset = 1'b1; start = 1'b1; #1;
        check("start_no_exec", we3, 0);
        tick();
        start = 1'b0; #1;
        check("run_running", running, 1);
        check("alu_we3", we3, 1);
        check("alu_wez", wez, 1);
        check("alu_op", op, 3'b001);
        check("alu_pc_we", pc_we, 1);
        check("cnt_before", instr_cnt, 16'h0000);
        tick();
        check("cnt_after_alu", instr_cnt, 16'h0001);

        // jz
        opcode = 6'b100101; z = 1'b1; #1;
        check("jz_z1_inc", s_inc, 0);
        check("jz_z1_writes", {we3, wez, pc_we}, 3'b001);
        check("jz_op", op, 3'b000);
        tick();
        z = 1'b0; #1;
        check("jz_z0_inc", s_inc, 1);
        check("jz_z0_writes", {we3, wez, pc_we}, 3'b001);
        tick();

        // jal, jal, ret, ret
        opcode = 6'b100111; #1;
        check("jal1_rre", s_rre, 1);
        check("jal1_inc", s_inc, 0);
        tick();
        check("jal1_call_err", call_err, 0);
        #1;
        check("jal2_rre", s_rre, 1);
        tick();
        check("jal2_call_err", call_err, 1);
        opcode = 6'b101000; #1;
        check("ret1_s_ret", s_ret, 1);
        check("ret1_pc_we", pc_we, 1);
        tick();
        check("ret1_call_err", call_err, 1);
        tick();
        check("ret2_call_err", call_err, 1);
        check("cnt_after_calls", instr_cnt, 16'd7);

        // Stop wins over start in RUN
        opcode = 6'b000100; stop = 1'b1; start = 1'b1; #1;
        check("stop_no_exec", {we3, pc_we}, 2'b00);
        tick();
        stop = 1'b0; start = 1'b0;
        check("stop_idle", running, 0);
        check("stop_cnt", instr_cnt, 16'd7);

        // Single step li
        opcode = 6'b100000; step_req = 1'b1; #1;
        check("step_li_we3", we3, 1);
        check("step_li_inm", s_inm, 1);
        check("step_ack_early", step_ack, 0);
        tick();
        step_req = 1'b0; #1;
        check("step_ack_pulse", step_ack, 1);
        check("step_cnt", instr_cnt, 16'd8);
        check("step_state", {running, halted}, 2'b00);
        tick();
        check("step_ack_drop", step_ack, 0);

        // Held step_req: one instruction per cycle
        opcode = 6'b000000; step_req = 1'b1;
        tick();
        check("hold_ack1", step_ack, 1);
        tick();
        check("hold_ack2", step_ack, 1);
        check("hold_cnt", instr_cnt, 16'd10);
        step_req = 1'b0;
        tick();
        check("hold_ack_off", step_ack, 0);

        // Halt in RUN
        start = 1'b1;
        tick();
        start = 1'b0; opcode = 6'b101001; #1;
        check("halt_pc_we", pc_we, 0);
        check("halt_we3", we3, 0);
        tick();
        check("halted", {running, halted}, 2'b01);
        check("halt_cnt", instr_cnt, 16'd11);
        opcode = 6'b000000; start = 1'b1; step_req = 1'b1; #1;
        check("halt_no_exec", {we3, pc_we}, 2'b00);
        tick();
        check("halt_sticky", halted, 1);
        check("halt_cnt_frozen", instr_cnt, 16'd11);
        check("halt_no_ack", step_ack, 0);
        reset = 1'b0;
        tick();
        start = 1'b0; step_req = 1'b0;
        check("rst_mid_halted", halted, 0);
        check("rst_mid_cnt", instr_cnt, 16'h0000);
        check("rst_mid_flags", {illegal, call_err}, 0);

        // Idle after reset release
        reset = 1'b1;
        tick();
        check("idle_after_rst", {running, instr_cnt}, 17'h0);

        // Illegal nops until the counter wraps
        start = 1'b1;
        tick();
        start = 1'b0; opcode = 6'b111111; #1;
        check("ill_inc", s_inc, 1);
        check("ill_writes", {we3, wez, pc_we}, 3'b001);
        repeat (65535) tick();
        check("ill_flag", illegal, 1);
        check("cnt_ffff", instr_cnt, 16'hFFFF);
        tick();
        check("cnt_wrap", instr_cnt, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
